// File: rtl/pn_pkg.sv
// Shared types and helpers for the PN chip generator: FSM state, LFSR lock state,
// and a table of maximal-length tap masks (right-shift LFSR, feedback into the MSB).
package pn_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // XNOR feedback locks up in all-ones, XOR feedback in all-zeros.
  function automatic logic [31:0] lock_state(input int width, input bit xnor_fb);
    logic [31:0] m;
    m = xnor_fb ? 32'((64'd1 << width) - 64'd1) : 32'd0;
    return m;
  endfunction

  // Bit i set means lfsr[i] is folded into the feedback; each mask is a primitive polynomial.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] t;
    case (width)
      3:       t = 32'h0000_0003;
      4:       t = 32'h0000_0009;
      5:       t = 32'h0000_0005;
      6:       t = 32'h0000_0021;
      7:       t = 32'h0000_0041;
      8:       t = 32'h0000_0071;
      9:       t = 32'h0000_0021;
      10:      t = 32'h0000_0081;
      11:      t = 32'h0000_0201;
      12:      t = 32'h0000_0053;
      13:      t = 32'h0000_001B;
      14:      t = 32'h0000_002B;
      15:      t = 32'h0000_4001;
      16:      t = 32'h0000_A011;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// LFSR register with XOR/XNOR feedback; load has priority over shift, one state per cycle.
// No backpressure: the controller decides each cycle whether to load, shift or hold.
module pn_lfsr_core #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter int              XNOR  = 1,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  output logic             chip_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb;

  always_comb begin
    fb = ^(lfsr_q & TAPS);
    if (XNOR != 0) fb = ~fb;
    lfsr_d = lfsr_q;
    if (load_i)       lfsr_d = load_val_i;
    else if (shift_i) lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign chip_o = lfsr_q[0];

endmodule

// File: rtl/pn_gen_param.sv
// Parametrised PN chip generator: one registered chip per enabled RUN cycle, chip visible the cycle after en.
// No backpressure on chips; optional data spreading (PN_SPREAD_EN) takes one data bit per period via data_ready_o.
module pn_gen_param
  import pn_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
  parameter int               XNOR   = 1,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               RESYNC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_in_i,
`ifdef PN_SPREAD_EN
  input  logic             data_in_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             spread_out_o,
`endif
  output logic             pn_o,
  output logic             pn_valid_o,
  output logic             epoch_o,
  output logic             lock_err_o,
  output logic             running_o
);

  localparam int               PERIOD = (2 ** WIDTH) - 1;
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] LOCK   = WIDTH'(lock_state(WIDTH, XNOR != 0));

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, seed_q;
  logic             pn_q, pn_valid_q, epoch_q, lock_err_q;

  logic             seed_lock, advance, wrap, core_load, chip;
  logic [WIDTH-1:0] seed_eff, core_val;

  assign seed_lock = (seed_in_i == LOCK);
  assign seed_eff  = seed_lock ? SEED : seed_in_i;
  assign advance   = !stop_i && !load_i && (state_q == RUN) && en_i;
  assign wrap      = advance && (cnt_q == LAST);
  assign core_load = stop_i || load_i || (wrap && (RESYNC != 0));
  assign core_val  = (load_i && !stop_i) ? seed_eff : seed_q;

  pn_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .XNOR  (XNOR),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (core_load),
    .load_val_i (core_val),
    .shift_i    (advance),
    .chip_o     (chip)
  );

  // Priority: stop > load > start > en; start in RUN falls through to the en branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seed_q     <= SEED;
      pn_q       <= 1'b0;
      pn_valid_q <= 1'b0;
      epoch_q    <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      epoch_q    <= 1'b0;
      lock_err_q <= 1'b0;
      if (stop_i) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        pn_q       <= 1'b0;
        pn_valid_q <= 1'b0;
      end else if (load_i) begin
        seed_q     <= seed_eff;
        cnt_q      <= '0;
        pn_valid_q <= 1'b0;
        lock_err_q <= seed_lock;
        if (start_i) state_q <= RUN;
      end else if (start_i && (state_q == IDLE)) begin
        state_q    <= RUN;
        pn_valid_q <= 1'b0;
      end else if (advance) begin
        pn_q       <= chip;
        pn_valid_q <= 1'b1;
        epoch_q    <= wrap;
        cnt_q      <= wrap ? '0 : cnt_q + 1'b1;
      end else begin
        pn_valid_q <= 1'b0;
      end
    end
  end

  assign pn_o       = pn_q;
  assign pn_valid_o = pn_valid_q;
  assign epoch_o    = epoch_q;
  assign lock_err_o = lock_err_q;
  assign running_o  = (state_q == RUN);

`ifdef PN_SPREAD_EN
  logic held_q, spread_q, bit_cur;

  // The period's data bit is decided on its first chip; nothing offered means a zero bit.
  assign data_ready_o = (state_q == RUN) && (cnt_q == '0);
  assign bit_cur      = (cnt_q == '0) ? (data_valid_i && data_in_i) : held_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 1'b0;
      spread_q <= 1'b0;
    end else if (stop_i) begin
      held_q   <= 1'b0;
      spread_q <= 1'b0;
    end else if (advance) begin
      held_q   <= bit_cur;
      spread_q <= bit_cur ^ chip;
    end
  end

  assign spread_out_o = spread_q;
`endif

endmodule

// File: tb/tb_pn_gen_param.sv
// Bench for pn_gen_param: default instance plus a WIDTH=5 XOR instance on shared stimulus,
// checked every cycle against a sequence-level model, plus hand-computed literal expectations.
module tb_pn_gen_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start, stop, en, load, dv, din;
  logic [4:0] seed;

  logic pn0, pv0, ep0, le0, run0;
  logic pn1, pv1, ep1, le1, run1;
`ifdef PN_SPREAD_EN
  logic dr0, so0, dr1, so1;
`endif

  always #5 clk = ~clk;

  pn_gen_param u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .en_i(en), .load_i(load),
    .seed_in_i(seed[3:0]),
`ifdef PN_SPREAD_EN
    .data_in_i(din), .data_valid_i(dv), .data_ready_o(dr0), .spread_out_o(so0),
`endif
    .pn_o(pn0), .pn_valid_o(pv0), .epoch_o(ep0), .lock_err_o(le0), .running_o(run0)
  );

  pn_gen_param #(.WIDTH(5), .TAPS(5'b00101), .XNOR(0), .SEED(5'b00001)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .en_i(en), .load_i(load),
    .seed_in_i(seed),
`ifdef PN_SPREAD_EN
    .data_in_i(din), .data_valid_i(dv), .data_ready_o(dr1), .spread_out_o(so1),
`endif
    .pn_o(pn1), .pn_valid_o(pv1), .epoch_o(ep1), .lock_err_o(le1), .running_o(run1)
  );

  // Per-instance configuration as seen by the model.
  int W[2]  = '{4, 5};
  int TP[2] = '{9, 5};
  int XN[2] = '{1, 0};
  int SD[2] = '{0, 1};

  bit m_run[2], m_pn[2], m_pv[2], m_ep[2], m_le[2], m_held[2], m_sp[2];
  int m_idx[2], m_seed[2];

  int n_chk = 0, n_pass = 0;
  bit cap = 0;
  bit q0[$], q1[$], qs0[$];
  int ep_cnt0 = 0, ep_cnt1 = 0, le_cnt0 = 0, le_cnt1 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
  endtask

  // k-th chip of the m-sequence from a seed: s[n+N] = (xnor?~:) XOR of s[n+i] for taps i.
  function automatic bit seq_bit(input int i, input int seedv, input int k);
    bit s[64];
    bit f;
    int n;
    n = W[i];
    for (int j = 0; j < n; j++) s[j] = bit'((seedv >> j) & 1);
    for (int j = n; j <= k; j++) begin
      f = 1'b0;
      for (int t = 0; t < n; t++) if (((TP[i] >> t) & 1) != 0) f = f ^ s[j - n + t];
      if (XN[i] != 0) f = ~f;
      s[j] = f;
    end
    return s[k];
  endfunction

  task automatic model_reset(input int i);
    m_run[i] = 0; m_pn[i] = 0; m_pv[i] = 0; m_ep[i] = 0; m_le[i] = 0;
    m_idx[i] = 0; m_seed[i] = SD[i]; m_held[i] = 0; m_sp[i] = 0;
  endtask

  task automatic model_step(input int i);
    int p, lk, sv;
    bit chip;
    p  = (1 << W[i]) - 1;
    lk = (XN[i] != 0) ? p : 0;
    sv = int'(seed) & p;
    m_ep[i] = 0;
    m_le[i] = 0;
    if (stop) begin
      m_run[i] = 0; m_idx[i] = 0; m_pn[i] = 0; m_pv[i] = 0; m_held[i] = 0; m_sp[i] = 0;
    end else if (load) begin
      if (sv == lk) begin sv = SD[i]; m_le[i] = 1; end
      m_seed[i] = sv; m_idx[i] = 0; m_pv[i] = 0;
      if (start) m_run[i] = 1;
    end else if (start && !m_run[i]) begin
      m_run[i] = 1; m_pv[i] = 0;
    end else if (m_run[i] && en) begin
      chip = seq_bit(i, m_seed[i], m_idx[i]);
      if (m_idx[i] == 0) m_held[i] = dv & din;
      m_sp[i]  = m_held[i] ^ chip;
      m_pn[i]  = chip;
      m_pv[i]  = 1;
      m_ep[i]  = (m_idx[i] == p - 1);
      m_idx[i] = m_ep[i] ? 0 : m_idx[i] + 1;
    end else begin
      m_pv[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_step(i);
    end
  end

  // Single compare process, one check per instance per cycle.
  always @(negedge clk) begin
    check("cyc_u0", {pn0, pv0, ep0, le0, run0}, {m_pn[0], m_pv[0], m_ep[0], m_le[0], m_run[0]});
    check("cyc_u1", {pn1, pv1, ep1, le1, run1}, {m_pn[1], m_pv[1], m_ep[1], m_le[1], m_run[1]});
`ifdef PN_SPREAD_EN
    check("spread_u0", {dr0, so0}, {m_run[0] && m_idx[0] == 0, m_sp[0]});
    check("spread_u1", {dr1, so1}, {m_run[1] && m_idx[1] == 0, m_sp[1]});
    if (cap && pv0) qs0.push_back(so0);
`endif
    if (cap && pv0) q0.push_back(pn0);
    if (cap && pv1) q1.push_back(pn1);
    if (cap && ep0) ep_cnt0++;
    if (cap && ep1) ep_cnt1++;
    if (le0) le_cnt0++;
    if (le1) le_cnt1++;
  end

  function automatic logic [63:0] packq(input int which, input int off, input int n);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < n; j++) begin
      if (which == 0 && off + j < q0.size())  v[j] = q0[off + j];
      if (which == 1 && off + j < q1.size())  v[j] = q1[off + j];
      if (which == 2 && off + j < qs0.size()) v[j] = qs0[off + j];
    end
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_caps();
    q0.delete(); q1.delete(); qs0.delete();
    ep_cnt0 = 0; ep_cnt1 = 0;
  endtask

  logic [14:0] exp0;
  logic [7:0]  exp1;
  logic [14:0] mpin;
  bit          seen[32];
  int          nstates, st;

  initial begin
    exp0 = 15'b111_0110_0101_0000;   // 0,0,0,0,1,0,1,0,0,1,1,0,1,1,1 (chip 0 in bit 0)
    exp1 = 8'b0010_0001;             // 1,0,0,0,0,1,0,0
    start = 0; stop = 0; en = 0; load = 0; seed = '0; dv = 0; din = 0;
    #1 rst_n = 1'b0;
    tick(2);
    check("rst_run0", run0, 1'b0);
    check("rst_pn0", {pn0, pv0, ep0, le0}, 4'b0000);
    check("rst_run1", run1, 1'b0);
    for (int k = 0; k < 15; k++) mpin[k] = seq_bit(0, 0, k);
    check("model_pin_w4", mpin, exp0);
    rst_n = 1'b1;
    tick(1);

    // Continuous chips from reset seed.
    clear_caps(); cap = 1;
    start = 1; tick(1); start = 0;
    en = 1; tick(45); en = 0; tick(2); cap = 0;
    check("len_u0", q0.size(), 45);
    check("first15_u0", packq(0, 0, 15), exp0);
    check("repeat_u0", packq(0, 15, 30), {exp0, exp0});
    check("epochs_u0", ep_cnt0, 3);
    check("epochs_u1", ep_cnt1, 1);
    check("first8_u1", packq(1, 0, 8), exp1);
    foreach (seen[k]) seen[k] = 0;
    nstates = 0;
    for (int p = 0; p < 31; p++) begin
      st = 0;
      for (int j = 0; j < 5; j++) st = st | (int'(q1[(p + j) % 31]) << j);
      if (st != 0 && !seen[st]) begin seen[st] = 1; nstates++; end
    end
    check("states_u1", nstates, 31);

    // Chip strobe toggling.
    stop = 1; tick(1); stop = 0;
    start = 1; tick(1); start = 0;
    for (int k = 0; k < 40; k++) begin en = k[0] ? 1'b0 : 1'b1; tick(1); end
    en = 0;

    // Seed loads: lock state for u0, then lock state for u1.
    le_cnt0 = 0; le_cnt1 = 0;
    load = 1; seed = 5'b01111; tick(1);
    seed = 5'b00000; tick(1); load = 0; tick(2);
    check("lockerr_u0", le_cnt0, 1);
    check("lockerr_u1", le_cnt1, 1);
    clear_caps(); cap = 1;
    en = 1; tick(15); en = 0; tick(2); cap = 0;
    check("after_lock_u0", packq(0, 0, 15), exp0);
    check("after_lock_u1", packq(1, 0, 8), exp1);

    // Start+stop together, then stop mid-period and restart.
    stop = 1; tick(1);
    start = 1; tick(1); start = 0; stop = 0; tick(1);
    check("startstop_run", {run0, run1, pn0}, 3'b000);
    start = 1; tick(1); start = 0;
    en = 1; tick(7); en = 0;
    stop = 1; tick(1); stop = 0;
    start = 1; tick(1); start = 0;
    clear_caps(); cap = 1;
    en = 1; tick(15); en = 0; tick(2); cap = 0;
    check("restart_u0", packq(0, 0, 15), exp0);
    check("restart_epoch_u0", ep_cnt0, 1);

`ifdef PN_SPREAD_EN
    stop = 1; tick(1); stop = 0;
    start = 1; tick(1); start = 0;
    clear_caps(); cap = 1;
    en = 1; dv = 1; din = 1; tick(1); dv = 0; din = 0;
    tick(29); en = 0; tick(2); cap = 0;
    check("spread_inv", packq(2, 0, 15), {49'd0, ~exp0});
    check("spread_plain", packq(2, 15, 15), {49'd0, exp0});
`endif

    // Randomized traffic with one asynchronous reset mid-run.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      stop  = (r < 3);
      load  = (r >= 3 && r < 7);
      start = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      dv    = $urandom_range(0, 1) != 0;
      din   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 9))
        0:       seed = 5'b01111;
        1:       seed = 5'b00000;
        2:       seed = 5'b11111;
        default: seed = 5'($urandom);
      endcase
      if (c == 700) begin
        #2 rst_n = 1'b0;
        tick(1);
        #2 rst_n = 1'b1;
      end
      tick(1);
    end
    start = 0; stop = 0; en = 0; load = 0; dv = 0; din = 0;
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pn_gen_param.md
Name: pn_gen_param

Overview:
Parametrised maximal-length PN chip generator for the DSSS transmit/receive chain. It is the successor of the fixed 4-bit XNOR generator and adds:
- configurable width and taps
- runtime seed load
- start/stop control and chip-enable pacing
- epoch (period boundary) marker and illegal-seed protection
It feeds the spreader/despreader, with one chip per enabled cycle.

Parameters:
WIDTH, 4, LFSR length N; sequence period PERIOD = 2^WIDTH-1 (localparam)
TAPS, 4'b1001, feedback tap mask; bit i set means lfsr[i] enters the feedback
XNOR, 1, 1 = XNOR feedback (lock state all-ones), 0 = XOR feedback (lock state all-zeros)
SEED, 4'b0000, reset/default seed; must not equal the lock state
RESYNC, 1, 1 = reload seed_reg into the LFSR at every epoch wrap

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: IDLE -> RUN
stop  in  1  pulse: any state -> IDLE
en  in  1  chip strobe; advances one chip when high in RUN
load  in  1  synchronous seed load
seed_in  in  WIDTH  seed value captured on load
pn  out  1  current chip (registered)
pn_valid  out  1  high for the cycle after each chip advance
epoch  out  1  one-cycle pulse on the last chip of a period
lock_err  out  1  one-cycle pulse when a loaded seed was illegal
running  out  1  high in RUN

Behaviour:
- Reset is asynchronous, active-low, on clk/rst_n:
  - lfsr=SEED, seed_reg=SEED, chip_cnt=0, state=IDLE
  - pn=0, pn_valid=0, epoch=0, lock_err=0, running=0
- Feedback: fb = ^(lfsr & TAPS), inverted when XNOR=1. Shift right: lfsr <= {fb, lfsr[WIDTH-1:1]}.
- FSM states:
  - IDLE: pn held at 0, no chip advance. start=1 -> RUN at the next edge.
  - RUN: running=1. On each en=1 edge:
    - pn<=lfsr[0], pn_valid<=1, lfsr shifts, chip_cnt++.
    - en=0: pn holds, pn_valid<=0.
  - stop=1 in RUN -> IDLE; lfsr<=seed_reg, chip_cnt<=0, pn<=0, pn_valid<=0.
- Latency: start sampled at edge k; the first en edge at k+1 or later shows pn = seed bit0 with pn_valid=1.
- Epoch: the en edge where chip_cnt==PERIOD-1 sets epoch<=1 (pulse aligned with that chip's pn_valid) and chip_cnt<=0. If RESYNC=1, lfsr<=seed_reg instead of the shift. chip_cnt never exceeds PERIOD-1.
- Load (any state):
  - seed_reg<=seed_in, lfsr<=seed_in, chip_cnt<=0; no chip emitted that cycle (pn_valid<=0).
  - If seed_in equals the lock state: SEED is substituted and lock_err pulses one cycle.
- Priority: stop > load > start > en. start and stop together: stop wins, remain/enter IDLE. load with start: load applies, state -> RUN.
- start while already in RUN is ignored.
- Reset mid-run aborts immediately; there is no pending-state carryover.

Optional Feature:
PN_SPREAD_EN
- Defined: adds ports data_in(1), data_valid(1), data_ready(1), spread_out(1).
  - Data is accepted on data_valid&&data_ready, only at chip_cnt==0 in RUN with en=1.
  - The accepted bit is held for PERIOD chips. spread_out = held_bit ^ pn, valid with pn_valid.
  - data_ready is high only in RUN at chip_cnt==0.
  - If no data is accepted at the boundary, spread_out = pn for that period.
- Undefined: these ports and this logic are absent.

Decomposition:
- Package pn_pkg:
  - state enum {IDLE, RUN}
  - function lock_state(WIDTH, XNOR)
  - default maximal tap masks for WIDTH 3..16
- One sub-module, pn_lfsr_core: LFSR register, feedback, load/shift. The FSM, counter, and outputs live in the top module.

Test Plan:
1. Defaults, reset, start, en=1 continuously -> first chips 0,0,0,0,1,0; epoch pulses on the 15th chip, then every 15 chips; the 15-chip sequence repeats exactly.
2. en toggled 1,0,1,0 in RUN -> pn changes only after en=1 edges; pn_valid alternates; epoch after 15 enabled cycles, not 15 clock cycles.
3. load seed_in=4'b1111 (lock state, XNOR) -> lock_err pulses once; lfsr=0000; the next chips equal the scenario-1 sequence.
4. start and stop asserted the same cycle -> running stays 0, pn=0; stop mid-period, then start -> sequence restarts from the seed with chip_cnt=0.
5. WIDTH=5, TAPS=5'b00101, XNOR=0, SEED=5'b00001 -> epoch period 31; all 31 nonzero states visited once per period.
6. PN_SPREAD_EN, data_in=1 accepted at the boundary -> spread_out = ~pn for 15 chips; next period with no data -> spread_out = pn.
